// File: rtl/thermometer_pkg.sv
// Shared types and helpers for the thermometer-code detector.
// Pure package: no state, safe to import from RTL and testbench alike.
package thermometer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  // Widest word is_therm() can inspect; narrower words are zero-extended.
  localparam int MAX_WIDTH = 64;

  typedef logic [MAX_WIDTH-1:0] word_t;

  function automatic int level_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Valid when bit0 is set and no 0->1 step exists scanning upward within w bits.
  function automatic logic is_therm(input word_t word, input int w);
    logic ok;
    ok = word[0];
    for (int i = 0; i < MAX_WIDTH - 1; i++) begin
      if ((i + 1 < w) && !word[i] && word[i+1]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/therm_check_comb.sv
// Combinational thermometer-code check: valid flag plus level (popcount),
// with the level forced to zero for invalid words.
module therm_check_comb
  import thermometer_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int LEVEL_W    = level_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] code,
  output logic                  valid_code,
  output logic [LEVEL_W-1:0]    level
);

  logic [LEVEL_W-1:0] ones;

  // NOTE: every always_comb output gets a default before any conditional
  // update, so no path can leave it unassigned and infer a latch.
  always_comb begin
    valid_code = is_therm(word_t'(code), DATA_WIDTH);
    ones       = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      ones = ones + LEVEL_W'(code[i]);
    end
    level = valid_code ? ones : '0;
  end

endmodule

// File: rtl/thermometer_code_detect.sv
// Registered LSB-anchored thermometer-code detector, one-cycle latency.
// Optional sticky error flag errSeen enabled by defining THERM_STICKY_ERR_EN.
module thermometer_code_detect
  import thermometer_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int LEVEL_W    = level_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  validIn,
  input  logic [DATA_WIDTH-1:0] codeIn,
  output logic                  validOut,
  output logic                  isThermometer,
  output logic [LEVEL_W-1:0]    level
`ifdef THERM_STICKY_ERR_EN
  ,
  output logic                  errSeen
`endif
);

  logic               chk_valid;
  logic [LEVEL_W-1:0] chk_level;

  therm_check_comb #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_check (
    .code      (codeIn),
    .valid_code(chk_valid),
    .level     (chk_level)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order between blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validOut      <= 1'b0;
      isThermometer <= 1'b0;
      level         <= '0;
    end else begin
      validOut <= validIn;
      if (validIn) begin
        isThermometer <= chk_valid;
        level         <= chk_level;
      end
    end
  end

`ifdef THERM_STICKY_ERR_EN
  // Latches on the first reported non-thermometer word until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errSeen <= 1'b0;
    end else if (validOut && !isThermometer) begin
      errSeen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_thermometer_code_detect.sv
// Directed self-checking bench for thermometer_code_detect (DATA_WIDTH=16).
// Define THERM_STICKY_ERR_EN to also exercise the sticky error flag.
module tb_thermometer_code_detect;

  localparam int DW = 16;
  localparam int LW = 5;

  logic          clk;
  logic          rst;
  logic          validIn;
  logic [DW-1:0] codeIn;
  logic          validOut;
  logic          isThermometer;
  logic [LW-1:0] level;
`ifdef THERM_STICKY_ERR_EN
  logic          errSeen;
`endif

  int total = 0;
  int bad   = 0;

  thermometer_code_detect #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .validIn      (validIn),
    .codeIn       (codeIn),
    .validOut     (validOut),
    .isThermometer(isThermometer),
    .level        (level)
`ifdef THERM_STICKY_ERR_EN
    ,
    .errSeen      (errSeen)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one word for a single edge; on return its result is visible.
  task automatic send(input logic [DW-1:0] c);
    @(negedge clk);
    validIn = 1'b1;
    codeIn  = c;
    @(negedge clk);
    validIn = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; validIn = 1'b0; codeIn = '0;
    #1;
    total++;
    if ({validOut, isThermometer, level} !== '0) begin
      bad++;
      $display("FAIL reset_state: got v=%b t=%b l=%0d want 0 0 0", validOut, isThermometer, level);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_boundaries();
    send(16'h0000);
    total++;
    if (validOut !== 1'b1 || isThermometer !== 1'b0 || level !== 5'd0) begin
      bad++;
      $display("FAIL zero_word: got v=%b t=%b l=%0d want 1 0 0", validOut, isThermometer, level);
    end
    send(16'hFFFF);
    total++;
    if (validOut !== 1'b1 || isThermometer !== 1'b1 || level !== 5'd16) begin
      bad++;
      $display("FAIL all_ones: got v=%b t=%b l=%0d want 1 1 16", validOut, isThermometer, level);
    end
    send(16'h0001);
    total++;
    if (isThermometer !== 1'b1 || level !== 5'd1) begin
      bad++;
      $display("FAIL single_one: got t=%b l=%0d want 1 1", isThermometer, level);
    end
  endtask

  task automatic test_bubbles();
    logic [DW-1:0] vec [5] = '{16'h0005, 16'h0002, 16'h8000, 16'h7FFE, 16'hFF7F};
    for (int i = 0; i < 5; i++) begin
      send(vec[i]);
      total++;
      if (validOut !== 1'b1 || isThermometer !== 1'b0 || level !== 5'd0) begin
        bad++;
        $display("FAIL bubble_%h: got v=%b t=%b l=%0d want 1 0 0", vec[i], validOut, isThermometer, level);
      end
    end
  endtask

  task automatic test_latency_hold();
    send(16'h00FF);
    total++;
    if (validOut !== 1'b1 || isThermometer !== 1'b1 || level !== 5'd8) begin
      bad++;
      $display("FAIL pulse_00ff: got v=%b t=%b l=%0d want 1 1 8", validOut, isThermometer, level);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (validOut !== 1'b0 || isThermometer !== 1'b1 || level !== 5'd8) begin
        bad++;
        $display("FAIL hold_%0d: got v=%b t=%b l=%0d want 0 1 8", c, validOut, isThermometer, level);
      end
    end
  endtask

  // Every code 0..65535 back-to-back; hits must be 2^k-1 in increasing order.
  task automatic test_sweep();
    int hits = 0;
    int gaps = 0;
    int stray = 0;
    @(negedge clk);
    for (int i = 0; i < 65536; i++) begin
      validIn = 1'b1;
      codeIn  = DW'(i);
      @(negedge clk);
      if (validOut !== 1'b1) gaps++;
      if (isThermometer === 1'b1) begin
        total++;
        if (i !== (1 << (hits + 1)) - 1 || level !== LW'(hits + 1)) begin
          bad++;
          $display("FAIL sweep_hit: code=%h got l=%0d want code=%h l=%0d", i[15:0], level, (1 << (hits + 1)) - 1, hits + 1);
        end
        hits++;
      end else if (level !== 5'd0) begin
        stray++;
      end
    end
    validIn = 1'b0;
    total++;
    if (hits !== 16) begin
      bad++;
      $display("FAIL sweep_count: got %0d want 16", hits);
    end
    total++;
    if (gaps !== 0) begin
      bad++;
      $display("FAIL sweep_valid_out: got %0d missing pulses want 0", gaps);
    end
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL sweep_level_zero: got %0d nonzero levels want 0", stray);
    end
  endtask

  task automatic test_async_reset();
    send(16'h003F);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({validOut, isThermometer, level} !== '0) begin
      bad++;
      $display("FAIL async_reset: got v=%b t=%b l=%0d want 0 0 0", validOut, isThermometer, level);
    end
    @(negedge clk);
    validIn = 1'b1;
    codeIn  = 16'h0003;
    @(negedge clk);
    total++;
    if ({validOut, isThermometer, level} !== '0) begin
      bad++;
      $display("FAIL input_in_reset: got v=%b t=%b l=%0d want 0 0 0", validOut, isThermometer, level);
    end
    rst    = 1'b0;
    codeIn = 16'h0007;
    @(negedge clk);
    validIn = 1'b0;
    total++;
    if (validOut !== 1'b1 || isThermometer !== 1'b1 || level !== 5'd3) begin
      bad++;
      $display("FAIL first_after_reset: got v=%b t=%b l=%0d want 1 1 3", validOut, isThermometer, level);
    end
  endtask

`ifdef THERM_STICKY_ERR_EN
  task automatic test_sticky_err();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(16'h0003);
    @(negedge clk);
    total++;
    if (errSeen !== 1'b0) begin
      bad++;
      $display("FAIL sticky_after_valid: got %b want 0", errSeen);
    end
    send(16'h0006);
    @(negedge clk);
    total++;
    if (errSeen !== 1'b1) begin
      bad++;
      $display("FAIL sticky_set: got %b want 1", errSeen);
    end
    send(16'h000F);
    @(negedge clk);
    total++;
    if (errSeen !== 1'b1) begin
      bad++;
      $display("FAIL sticky_hold: got %b want 1", errSeen);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (errSeen !== 1'b0) begin
      bad++;
      $display("FAIL sticky_clear: got %b want 0", errSeen);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_boundaries();
    test_bubbles();
    test_latency_hold();
    test_sweep();
    test_async_reset();
`ifdef THERM_STICKY_ERR_EN
    test_sticky_err();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
